// File: rtl/timer_ctrl.sv
// Front-panel controller: debounces START/LOAD, validates BCD minutes, sequences the countdown timer.
// Optional AUTO_RESTART_EN: START in DONE reloads the held digits and resumes counting without a new press.
module timer_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic [3:0] sw_tens,
    input  logic [3:0] sw_ones,
    input  logic       done_in,
    input  logic       err_in,
    output logic       load,
    output logic       ce,
    output logic [3:0] ld_tens,
    output logic [3:0] ld_ones,
    output logic [2:0] state,
    output logic       err_led
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOADED = 3'b001,
        S_RUN    = 3'b010,
        S_PAUSE  = 3'b011,
        S_DONE   = 3'b100,
        S_ERR    = 3'b101
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 0 is START, bit 1 is LOAD throughout the conditioning path.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q, arm_q, press;
    logic [DB_W-1:0] cnt_q [2];
    logic [1:0]      fill_q;
    logic            start_p, load_p, valid;

    assign btn_raw = {btn_load, btn_start};

    // arm_q blocks the press pulse until the line has been seen released after reset,
    // so a button held through reset release cannot fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            arm_q      <= '0;
            fill_q     <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            for (int i = 0; i < 2; i++) begin
                if (fill_q == 2'd2 && !sync2_q[i]) arm_q[i] <= 1'b1;
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press   = deb_q & ~deb_prev_q & arm_q;
    assign start_p = press[0];
    assign load_p  = press[1];
    assign valid   = (sw_tens <= 4'd9) && (sw_ones <= 4'd9);

    state_t     state_q, state_d;
    logic       load_q, ce_q, err_led_q, load_act, use_sw, accept_ld;
    logic [3:0] ld_tens_q, ld_ones_q;
`ifdef AUTO_RESTART_EN
    logic       auto_q, auto_d;
`endif

    always_comb begin
        state_d   = state_q;
        load_act  = 1'b0;
        use_sw    = 1'b1;
        accept_ld = 1'b0;
`ifdef AUTO_RESTART_EN
        auto_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE:   accept_ld = 1'b1;
            S_LOADED: begin
                accept_ld = 1'b1;
                if (start_p) state_d = S_RUN;
`ifdef AUTO_RESTART_EN
                else if (auto_q) state_d = S_RUN;
`endif
            end
            S_RUN: begin
                if (err_in)       state_d = S_ERR;
                else if (done_in) state_d = S_DONE;
                else if (start_p) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                accept_ld = 1'b1;
                if (start_p) state_d = S_RUN;
            end
            S_DONE: begin
                accept_ld = 1'b1;
`ifdef AUTO_RESTART_EN
                if (start_p) begin
                    load_act = 1'b1;
                    use_sw   = 1'b0;
                    auto_d   = 1'b1;
                end
`endif
            end
            S_ERR:    accept_ld = 1'b1;
            default:  state_d = S_IDLE;
        endcase
        // A LOAD press overrides any START-driven move decided above.
        if (accept_ld && load_p) begin
            load_act = valid;
            use_sw   = 1'b1;
            state_d  = valid ? S_LOADED : S_ERR;
`ifdef AUTO_RESTART_EN
            auto_d   = 1'b0;
`endif
        end else if (load_act) begin
            state_d = S_LOADED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            ce_q      <= 1'b0;
            err_led_q <= 1'b0;
            ld_tens_q <= '0;
            ld_ones_q <= '0;
`ifdef AUTO_RESTART_EN
            auto_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            load_q    <= load_act;
            ce_q      <= (state_d == S_RUN);
            err_led_q <= (state_d == S_ERR);
            if (load_act && use_sw) begin
                ld_tens_q <= sw_tens;
                ld_ones_q <= sw_ones;
            end
`ifdef AUTO_RESTART_EN
            auto_q    <= auto_d;
`endif
        end
    end

    assign load    = load_q;
    assign ce      = ce_q;
    assign err_led = err_led_q;
    assign ld_tens = ld_tens_q;
    assign ld_ones = ld_ones_q;
    assign state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus random button/switch traffic
// compared every cycle against a window-based behavioural model of the front panel.
module tb_timer_ctrl;
    localparam int DB = 8;
    localparam int HMAX = 8192;

    logic       clk = 1'b0, reset = 1'b0, btn_start = 1'b0, btn_load = 1'b0;
    logic [3:0] sw_tens = '0, sw_ones = '0;
    logic       done_in = 1'b0, err_in = 1'b0;
    logic       load, ce, err_led;
    logic [3:0] ld_tens, ld_ones;
    logic [2:0] state;

    timer_ctrl #(.DB_CYCLES(DB), .DB_W(4)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_load(btn_load),
        .sw_tens(sw_tens), .sw_ones(sw_ones), .done_in(done_in), .err_in(err_in),
        .load(load), .ce(ce), .ld_tens(ld_tens), .ld_ones(ld_ones),
        .state(state), .err_led(err_led)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, load_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a button's debounced level flips once the last DB synchronized samples
    // (raw samples delayed two clocks) all disagree with it.
    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4, M_ERR = 5;
    int       m_state, n;
    bit       m_load, m_ce, m_err, m_auto;
    bit [3:0] m_ten, m_one;
    bit       debm [2], armm [2], rose [2];
    bit       rawh [2][HMAX];

    function automatic bit rv(input int b, input int e);
        if (e < 1 || e >= HMAX) return 1'b0;
        return rawh[b][e];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0; m_state = M_IDLE; m_load = 0; m_ce = 0; m_err = 0; m_auto = 0;
            m_ten = 0; m_one = 0;
            for (int b = 0; b < 2; b++) begin debm[b] = 0; armm[b] = 0; rose[b] = 0; end
        end else begin
            bit sp, lp, valid, la, usesw, nauto, all_diff;
            int ns;
            n++;
            if (n < HMAX) begin rawh[0][n] = btn_start; rawh[1][n] = btn_load; end
            sp = rose[0]; lp = rose[1];
            valid = (sw_tens <= 9) && (sw_ones <= 9);
            la = 0; usesw = 1; nauto = 0; ns = m_state;
            case (m_state)
                M_IDLE:   if (lp) begin if (valid) la = 1; else ns = M_ERR; end
                M_LOADED: if (lp) begin if (valid) la = 1; else ns = M_ERR; end
                          else if (sp || m_auto) ns = M_RUN;
                M_RUN:    if (err_in) ns = M_ERR; else if (done_in) ns = M_DONE;
                          else if (sp) ns = M_PAUSE;
                M_PAUSE:  if (lp) begin if (valid) la = 1; else ns = M_ERR; end
                          else if (sp) ns = M_RUN;
                M_DONE: begin
                    if (lp) begin if (valid) la = 1; else ns = M_ERR; end
`ifdef AUTO_RESTART_EN
                    else if (sp) begin la = 1; usesw = 0; nauto = 1; end
`endif
                end
                M_ERR:    if (lp && valid) la = 1;
                default:  ns = M_IDLE;
            endcase
            if (la) begin
                ns = M_LOADED;
                if (usesw) begin m_ten = sw_tens; m_one = sw_ones; end
            end
            m_state = ns; m_load = la; m_auto = nauto;
            m_ce = (ns == M_RUN); m_err = (ns == M_ERR);
            for (int b = 0; b < 2; b++) begin
                if (n - 2 >= 1 && rv(b, n - 2) == 1'b0) armm[b] = 1;
                all_diff = 1;
                for (int j = n - 1 - DB; j <= n - 2; j++)
                    if (rv(b, j) == debm[b]) all_diff = 0;
                rose[b] = 0;
                if (all_diff) begin
                    debm[b] = ~debm[b];
                    rose[b] = debm[b] && armm[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && cmp_en) begin
            chk("state", state, m_state);
            chk("load", load, m_load);
            chk("ce", ce, m_ce);
            chk("ld_tens", ld_tens, m_ten);
            chk("ld_ones", ld_ones, m_one);
            chk("err_led", err_led, m_err);
        end
        if (reset && load === 1'b1) load_cnt++;
    end

    task automatic press(input bit s, input bit l);
        btn_start = s; btn_load = l;
        repeat (DB + 6) @(negedge clk);
        btn_start = 0; btn_load = 0;
        repeat (DB + 6) @(negedge clk);
    endtask

    initial begin
        int lc0, len;
        #1;
        chk("rst_state", state, 0); chk("rst_ce", ce, 0); chk("rst_load", load, 0);
        chk("rst_err", err_led, 0); chk("rst_ld", {ld_tens, ld_ones}, 0);
        repeat (3) @(negedge clk);
        reset = 1; cmp_en = 1;
        repeat (4) @(negedge clk);

        // Load 25: strobe exactly DB+3 clocks after the press.
        sw_tens = 2; sw_ones = 5; btn_load = 1;
        repeat (DB + 2) @(negedge clk);
        chk("t1_early", load, 0);
        @(negedge clk);
        chk("t1_load", load, 1); chk("t1_tens", ld_tens, 2); chk("t1_ones", ld_ones, 5);
        chk("t1_state", state, 1);
        @(negedge clk);
        chk("t1_strobe1", load, 0);
        btn_load = 0;
        repeat (DB + 6) @(negedge clk);

        // Bouncing START yields a single press.
        btn_start = 1; repeat (3) @(negedge clk);
        btn_start = 0; repeat (3) @(negedge clk);
        press(1, 0);
        chk("t2_state", state, 2); chk("t2_ce", ce, 1);

        press(1, 0);
        chk("t3_pause", state, 3); chk("t3_ce0", ce, 0);
        press(1, 0);
        chk("t3_run", state, 2); chk("t3_ce1", ce, 1);
        done_in = 1; @(negedge clk); done_in = 0;
        chk("t3_done", state, 4); chk("t3_ce_drop", ce, 0);

        // Invalid switches from IDLE.
        reset = 0; repeat (2) @(negedge clk); reset = 1; repeat (4) @(negedge clk);
        sw_tens = 0; sw_ones = 12; lc0 = load_cnt;
        press(0, 1);
        chk("t4_err", state, 5); chk("t4_led", err_led, 1); chk("t4_noload", load_cnt - lc0, 0);
        sw_ones = 3; press(0, 1);
        chk("t4_reload", load_cnt - lc0, 1); chk("t4_ones", ld_ones, 3);
        chk("t4_led0", err_led, 0); chk("t4_state", state, 1);

        press(1, 0);
        done_in = 1; err_in = 1; @(negedge clk); done_in = 0; err_in = 0;
        chk("t5_errwins", state, 5);
        sw_tens = 2; sw_ones = 5;
        press(0, 1); press(1, 0); press(1, 0);
        chk("t5_pause", state, 3);
        lc0 = load_cnt;
        press(1, 1);
        chk("t5_loadwins", state, 1); chk("t5_pulse", load_cnt - lc0, 1);

        // Reset mid-RUN with LOAD held through release.
        press(1, 0);
        btn_load = 1;
        @(posedge clk); #2 reset = 0; #1;
        chk("t6_ce_async", ce, 0); chk("t6_state", state, 0);
        @(negedge clk); @(negedge clk); reset = 1;
        lc0 = load_cnt;
        repeat (DB + 6) @(negedge clk);
        chk("t6_held", state, 0); chk("t6_nopulse", load_cnt - lc0, 0);
        btn_load = 0; repeat (DB + 6) @(negedge clk);
        press(0, 1);
        chk("t6_rearm", state, 1);

        press(1, 0);
        done_in = 1; @(negedge clk); done_in = 0;
        chk("t7_done", state, 4);
        sw_tens = 7; sw_ones = 7; lc0 = load_cnt;
`ifdef AUTO_RESTART_EN
        btn_start = 1;
        repeat (DB + 3) @(negedge clk);
        chk("t7_load", load, 1); chk("t7_ce_lo", ce, 0); chk("t7_loaded", state, 1);
        @(negedge clk);
        chk("t7_ce", ce, 1); chk("t7_run", state, 2);
        chk("t7_tens", ld_tens, 2); chk("t7_ones", ld_ones, 5);
        btn_start = 0; repeat (DB + 6) @(negedge clk);
`else
        press(1, 0);
        chk("t7_ignored", state, 4); chk("t7_noload", load_cnt - lc0, 0);
`endif

        for (int k = 0; k < 120; k++) begin
            sw_tens = 4'($urandom_range(0, 10)); sw_ones = 4'($urandom_range(0, 10));
            btn_start = 1'($urandom_range(0, 1));
            btn_load = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 2 * DB + 4);
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                done_in = ($urandom_range(0, 15) == 0);
                err_in = ($urandom_range(0, 40) == 0);
            end
        end
        done_in = 0; err_in = 0; btn_start = 0; btn_load = 0;
        repeat (4) @(negedge clk);
        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Front-panel controller sitting directly upstream of the countdown timer. Conditions the raw START and LOAD push-buttons and validates the BCD minute switches. Runs the IDLE/LOADED/RUN/PAUSE/DONE/ERR sequence that produces the timer's one-cycle load strobe, count-enable level and latched minute digits. Consumes the timer's done and error indications.

Parameters:
DB_CYCLES, 1000000, stable-level cycles required before a button change is accepted (10 ms at 100 MHz)
DB_W, 20, width of each debounce counter; must hold DB_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
btn_start  input  1  raw START button, asynchronous, active-high
btn_load  input  1  raw LOAD button, asynchronous, active-high
sw_tens  input  4  minute tens digit from switches, BCD
sw_ones  input  4  minute ones digit from switches, BCD
done_in  input  1  timer reached 00:00, level
err_in  input  1  timer error indication, level
load  output  1  one-cycle load strobe to timer
ce  output  1  count enable to timer, level
ld_tens  output  4  latched tens digit presented to timer
ld_ones  output  4  latched ones digit presented to timer
state  output  3  current FSM state encoding
err_led  output  1  high while in ERR

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE(000). load=0, ce=0, ld_tens=0, ld_ones=0, err_led=0. Synchronizers, debounce counters and debounced levels all clear to 0.
- Button conditioning, per button:
  - Two-flop synchronizer feeds a debounce counter.
  - The counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the count reaches DB_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A rising edge of the debounced level gives an internal 1-cycle press pulse (start_p, load_p).
  - A glitch shorter than DB_CYCLES produces no pulse.
  - Latency from a clean press to its pulse: DB_CYCLES+3 cycles.
- valid = (sw_tens<=9) && (sw_ones<=9), evaluated combinationally in the cycle of load_p.
- Load action:
  - ld_tens/ld_ones capture the switches.
  - load=1 in the following cycle only.
  - Next state is LOADED.
- All outputs are registered. ce=1 exactly while state==RUN.
- States:
  - IDLE(000): load_p & valid -> load action. load_p & !valid -> ERR. start_p ignored.
  - LOADED(001): start_p -> RUN. load_p -> re-load (valid) or ERR (invalid).
  - RUN(010):
    - err_in -> ERR.
    - Else done_in -> DONE.
    - Else start_p -> PAUSE.
    - load_p ignored.
    - ce drops in the cycle after done_in or err_in is sampled high.
  - PAUSE(011): start_p -> RUN. load_p -> re-load or ERR.
  - DONE(100): load_p -> re-load or ERR. start_p ignored unless AUTO_RESTART_EN is defined.
  - ERR(101): err_led=1. load_p & valid -> load action and err_led clears. Everything else is ignored.
- Priority:
  - err_in outranks done_in.
  - done_in outranks start_p.
  - If start_p and load_p arrive in the same cycle in a state that accepts load, load wins and start_p is discarded.
- Digit reuse: ld_tens/ld_ones hold their value in every state except a load action, so a DONE->re-load may reuse them.
- Reset mid-RUN: ce drops immediately and asynchronously. A button held through reset release gives no pulse until it is released and pressed again.
- Unused encodings 110/111 go to IDLE on the next clock.

Optional Feature:
AUTO_RESTART_EN
- Defined: in DONE, start_p performs a load action from ld_tens/ld_ones (switches are not resampled). load=1 for one cycle, then the FSM goes LOADED -> RUN on the next cycle without a further press, so ce rises 2 cycles after start_p.
- Undefined: start_p in DONE is ignored and a fresh LOAD press is required.

Test Plan:
1. DB_CYCLES=8. Press btn_load with sw_tens=2, sw_ones=5 -> after 11 cycles load=1 for one cycle, ld_tens=2, ld_ones=5, state=001.
2. Bounce btn_start 1-0-1 at 3-cycle intervals, then hold -> exactly one start_p. state 001->010 and ce=1.
3. RUN, press start -> PAUSE with ce=0. Press start again -> RUN with ce=1. Drive done_in=1 -> next cycle ce=0, state=100.
4. IDLE with sw_ones=12 and a load press -> state=101, err_led=1, load never pulses. Set sw_ones=3 and press load -> load=1, ld_ones=3, err_led=0.
5. RUN with done_in and err_in high in the same cycle -> state=101. Separately, start and load pressed together in PAUSE -> load=1, state=001.
6. Assert reset=0 mid-RUN -> ce=0 immediately. With AUTO_RESTART_EN, a start press in DONE -> load pulse, then ce=1 two cycles after start_p with the previous digits.
